activation_backprop: RTL and testbench

- Backward-pass partner of the sigmoid activation LUT.
- Takes a stored activation y (0..15; 16 = 1.0, 8 = 0.5) and an upstream error, and returns the local gradient err * y(1-y).
- Three-stage valid/ready pipeline between the error-propagation datapath and the weight-update unit.
- Carries a running sample counter for the training controller.

---
 rtl/nn_pkg.sv | 9 +
 rtl/activation_backprop_sat_round.sv | 20 ++
 rtl/activation_backprop.sv | 82 ++++++++
 tb/tb_activation_backprop.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared activation constants, default widths and data types for the nn datapath blocks.
package nn_pkg;
  localparam int ACT_MAX = 15;
  localparam int ACT_ONE = 16;
  localparam int ERR_W_DEF = 8;
  localparam int OUT_W_DEF = 8;
  typedef logic [7:0] act_t;
  typedef logic signed [ERR_W_DEF-1:0] err_t;
endpackage

// File: rtl/activation_backprop_sat_round.sv
// sat_round: round-half-up arithmetic right shift followed by saturation to a signed OUT_W result.
module sat_round #(
  parameter int IN_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6
) (
  input  logic signed [IN_W-1:0]  p,
  output logic signed [OUT_W-1:0] r,
  output logic                    sat
);
  // Wide enough that neither the rounding add nor the limit constants can overflow.
  localparam int W = IN_W + OUT_W + 1;
  localparam logic signed [W-1:0] HALF = W'(1) <<< (SHIFT - 1);
  localparam logic signed [W-1:0] MAX = (W'(1) <<< (OUT_W - 1)) - W'(1);
  localparam logic signed [W-1:0] MIN = -(W'(1) <<< (OUT_W - 1));
  logic signed [W-1:0] s;
  assign s = (W'(p) + HALF) >>> SHIFT;
  assign sat = s > MAX || s < MIN;
  assign r = s > MAX ? OUT_W'(MAX) : s < MIN ? OUT_W'(MIN) : OUT_W'(s);
endmodule

// File: rtl/activation_backprop.sv
// activation_backprop: 3-stage valid/ready pipeline computing err * y(1-y) for the sigmoid LUT backward pass.
// Optional ACT_BACKPROP_SAT_CNT_EN adds a saturating sat_cnt port counting saturated/clamped outputs.
module activation_backprop
  import nn_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int OUT_SHIFT = 6,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  act_t                    in_act,
  input  logic signed [ERR_W-1:0] in_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_grad,
  output logic                    out_sat,
  output logic                    busy,
  output logic [CNT_W-1:0]        sample_cnt
`ifdef ACT_BACKPROP_SAT_CNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);
  localparam int P_W = ERR_W + 8;
  logic en, accept, v1, v2, clamp1, clamp2, sat_r;
  logic [6:0] d, d1;
  logic signed [ERR_W-1:0] err1;
  logic signed [P_W-1:0] p2;
  logic signed [OUT_W-1:0] grad_r;
  act_t a;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign accept = in_valid && in_ready;
  assign busy = v1 || v2 || out_valid;
  assign a = in_act > act_t'(ACT_MAX) ? act_t'(ACT_MAX) : in_act;
  assign d = 7'(a * (act_t'(ACT_ONE) - a));
  sat_round #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(OUT_SHIFT)) u_sat_round (
    .p(p2),
    .r(grad_r),
    .sat(sat_r)
  );
  // Data registers load on every enabled cycle; the valid bits alone mark bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      err1 <= '0;
      clamp1 <= 1'b0;
      p2 <= '0;
      clamp2 <= 1'b0;
      out_valid <= 1'b0;
      out_grad <= '0;
      out_sat <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (en) begin
        v1 <= accept;
        d1 <= d;
        err1 <= in_err;
        clamp1 <= in_act > act_t'(ACT_MAX);
        v2 <= v1;
        p2 <= $signed(err1) * $signed({1'b0, d1});
        clamp2 <= clamp1;
        out_valid <= v2;
        out_grad <= grad_r;
        out_sat <= sat_r || clamp2;
      end
      if (out_valid && out_ready) sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end
`ifdef ACT_BACKPROP_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_activation_backprop.sv
// tb_activation_backprop: randomized and directed checks of activation_backprop against an arithmetic reference model.
module tb_activation_backprop;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid, out_sat, busy;
  logic [7:0] in_act = '0;
  logic signed [7:0] in_err = '0, out_grad;
  logic [15:0] sample_cnt;
  logic in_valid2 = 1'b0, out_ready2 = 1'b1, in_ready2, out_valid2, out_sat2, busy2;
  logic [7:0] in_act2 = '0;
  logic signed [7:0] in_err2 = '0, out_grad2;
  logic [3:0] sample_cnt2;
`ifdef ACT_BACKPROP_SAT_CNT_EN
  logic [15:0] sat_cnt, sat_cnt2;
`endif
  typedef struct {int g; bit s;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  activation_backprop dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad), .out_sat(out_sat), .busy(busy),
    .sample_cnt(sample_cnt)
`ifdef ACT_BACKPROP_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  activation_backprop #(.OUT_SHIFT(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_act(in_act2), .in_err(in_err2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_grad(out_grad2), .out_sat(out_sat2), .busy(busy2),
    .sample_cnt(sample_cnt2)
`ifdef ACT_BACKPROP_SAT_CNT_EN
    , .sat_cnt(sat_cnt2)
`endif
  );

  // Reference: clamp the activation, scale the error by y(1-y), round half up, saturate to 8 bits.
  function automatic exp_t model(input int act, input int err, input int shift);
    exp_t e;
    int a, r;
    a = act > 15 ? 15 : act;
    r = (err * a * (16 - a) + (1 << (shift - 1))) >>> shift;
    e.g = r > 127 ? 127 : (r < -128 ? -128 : r);
    e.s = (e.g != r) || (act > 15);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst = 1'b0;
    #1;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_valid_busy got %b%b want 00", out_valid, busy); end
    n_cmp++;
    if (sample_cnt !== 16'd0 || out_grad !== 8'sd0 || out_sat !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs cnt %0d grad %0d sat %b want 0 0 0", sample_cnt, out_grad, out_sat);
    end
    n_cmp++;
  endtask

  task automatic test_single();
    exp_t e;
    e = model(8, 64, 6);
    in_act = 8'd8; in_err = 8'sd64; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early1 out_valid got %b want 0", out_valid); end
    n_cmp++;
    step(); #1;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early2 out_valid got %b want 0", out_valid); end
    n_cmp++;
    step(); #1;
    if (out_valid !== 1'b1 || int'(out_grad) !== e.g || out_sat !== e.s) begin
      n_err++; $display("FAIL single_result valid %b grad %0d sat %b want 1 %0d %b", out_valid, out_grad, out_sat, e.g, e.s);
    end
    n_cmp++;
    step(); #1;
    if (sample_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_cnt cnt %0d valid %b want 1 0", sample_cnt, out_valid);
    end
    n_cmp++;
  endtask

  // Feeds n samples on consecutive cycles and expects outputs on consecutive cycles three cycles later.
  task automatic test_directed(input string name, input int n, input int acts[4], input int errs[4]);
    exp_t e;
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = c < n;
      if (c < n) begin in_act = 8'(acts[c]); in_err = 8'(errs[c]); end
      #1;
      if (out_valid) begin
        e = model(acts[got], errs[got], 6);
        if (c !== 3 + got || int'(out_grad) !== e.g || out_sat !== e.s) begin
          n_err++;
          $display("FAIL %s_out%0d cycle %0d grad %0d sat %b want cycle %0d grad %0d sat %b", name, got, c, out_grad, out_sat, 3 + got, e.g, e.s);
        end
        n_cmp++;
        got++;
      end
      step();
    end
    in_valid = 1'b0;
    if (got !== n) begin n_err++; $display("FAIL %s_count got %0d want %0d", name, got, n); end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    test_directed("b2b", 3, '{8, 0, 4, 0}, '{-128, 100, 10, 0});
  endtask

  task automatic test_clamp();
    test_directed("clamp", 2, '{200, 15, 0, 0}, '{127, 127, 0, 0});
  endtask

  task automatic test_backpressure();
    int acts[5], errs[5];
    int sent = 0, got = 0;
    bit prev_stall = 1'b0;
    logic signed [7:0] held = '0;
    logic [15:0] base;
    exp_t e;
    base = sample_cnt;
    q.delete();
    for (int i = 0; i < 5; i++) begin acts[i] = $urandom_range(0, 15); errs[i] = $signed(8'($urandom)); end
    for (int c = 0; c < 20; c++) begin
      in_valid = sent < 5;
      if (sent < 5) begin in_act = 8'(acts[sent]); in_err = 8'(errs[sent]); end
      out_ready = !(c >= 3 && c < 7);
      #1;
      if (out_valid && !out_ready) begin
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
        n_cmp++;
        if (prev_stall) begin
          if (out_grad !== held) begin n_err++; $display("FAIL bp_hold cycle %0d got %0d want %0d", c, out_grad, held); end
          n_cmp++;
        end
        held = out_grad;
        prev_stall = 1'b1;
      end else prev_stall = 1'b0;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        if (int'(out_grad) !== e.g || out_sat !== e.s) begin
          n_err++; $display("FAIL bp_out%0d grad %0d sat %b want %0d %b", got, out_grad, out_sat, e.g, e.s);
        end
        n_cmp++;
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(model(acts[sent], errs[sent], 6)); sent++; end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (got !== 5 || sample_cnt !== 16'(base + 16'd5)) begin
      n_err++; $display("FAIL bp_totals got %0d cnt %0d want 5 %0d", got, sample_cnt, 16'(base + 16'd5));
    end
    n_cmp++;
  endtask

  task automatic test_reset_flight();
    exp_t e;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_act = 8'($urandom_range(0, 15)); in_err = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sample_cnt !== 16'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_flight valid %b busy %b cnt %0d ready %b want 0 0 0 1", out_valid, busy, sample_cnt, in_ready);
    end
    n_cmp++;
    step();
    rst = 1'b0;
    e = model(4, -10, 6);
    in_act = 8'd4; in_err = -8'sd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); #1;
    if (out_valid !== 1'b1 || int'(out_grad) !== e.g || out_sat !== e.s) begin
      n_err++; $display("FAIL rst_next valid %b grad %0d sat %b want 1 %0d %b", out_valid, out_grad, out_sat, e.g, e.s);
    end
    n_cmp++;
    step();
  endtask

  task automatic test_random();
    int act, err, got = 0, sent = 0;
    logic [15:0] base;
    exp_t e;
    base = sample_cnt;
    q.delete();
    for (int c = 0; c < 320; c++) begin
      act = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
      err = $signed(8'($urandom));
      in_valid = (c < 300) && ($urandom_range(0, 3) != 0);
      in_act = 8'(act); in_err = 8'(err);
      out_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra output grad %0d with empty queue", out_grad);
        end else begin
          e = q.pop_front();
          if (int'(out_grad) !== e.g || out_sat !== e.s) begin
            n_err++; $display("FAIL rand_out%0d grad %0d sat %b want %0d %b", got, out_grad, out_sat, e.g, e.s);
          end
        end
        n_cmp++;
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(model(act, err, 6)); sent++; end
      step();
    end
    in_valid = 1'b0;
    if (q.size() !== 0 || got !== sent || sample_cnt !== 16'(base + 16'(sent))) begin
      n_err++; $display("FAIL rand_totals left %0d got %0d sent %0d cnt %0d", q.size(), got, sent, sample_cnt);
    end
    n_cmp++;
  endtask

  task automatic test_param_dut();
    exp_t e;
    int got = 0;
    out_ready2 = 1'b1;
    for (int c = 0; c < 25; c++) begin
      in_valid2 = c < 17;
      in_act2 = (c == 0) ? 8'd8 : 8'd4;
      in_err2 = (c == 0) ? 8'sd127 : 8'sd1;
      #1;
      if (out_valid2) begin
        e = (got == 0) ? model(8, 127, 4) : model(4, 1, 4);
        if (int'(out_grad2) !== e.g || out_sat2 !== e.s) begin
          n_err++; $display("FAIL p2_out%0d grad %0d sat %b want %0d %b", got, out_grad2, out_sat2, e.g, e.s);
        end
        n_cmp++;
        got++;
      end
      step();
    end
    in_valid2 = 1'b0;
    if (got !== 17 || sample_cnt2 !== 4'(17)) begin
      n_err++; $display("FAIL p2_wrap got %0d cnt %0d want 17 %0d", got, sample_cnt2, 4'(17));
    end
    n_cmp++;
`ifdef ACT_BACKPROP_SAT_CNT_EN
    if (sat_cnt2 !== 16'd1) begin n_err++; $display("FAIL p2_sat_cnt got %0d want 1", sat_cnt2); end
    n_cmp++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clamp();
    test_backpressure();
    test_reset_flight();
    test_random();
    test_param_dut();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
